// File: rtl/lsu_dcache_fill_way_sel.sv
// D-cache fill replacement controller.
// Accepts a line-fill request, reads the set's valid bits one cycle later and
// picks the lowest-numbered invalid way, or a pseudo-random victim from a
// 5-bit LFSR when every way is valid. The choice is held until acknowledged.
module lsu_dcache_fill_way_sel #(
    parameter int         IDX_W   = 7,
    parameter logic [4:0] LFSR_SD = 5'b11111
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             fill_req_vld,
    input  logic [IDX_W-1:0] fill_req_idx,
    output logic             fill_req_rdy,
    output logic             vld_rd_en,
    output logic [IDX_W-1:0] vld_rd_idx,
    input  logic [3:0]       vld_rd_data,
    input  logic             fill_cancel,
    output logic             fill_way_vld,
    output logic [1:0]       fill_way,
    output logic [IDX_W-1:0] fill_way_idx,
    output logic             fill_evict,
    input  logic             fill_way_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t           state_p0;
    state_t           state_nxt;
    logic [IDX_W-1:0] req_idx_p0;
    logic [4:0]       lfsr_p0;
    logic [1:0]       fill_way_p1;
    logic [IDX_W-1:0] fill_way_idx_p1;
    logic             fill_evict_p1;
    logic             all_vld;
    logic             sel_en;
    logic [1:0]       sel_way;

    // Lowest-numbered way whose valid bit is clear (caller guarantees one exists).
    function automatic logic [1:0] first_invalid(input logic [3:0] v);
        logic [1:0] w;
        w = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) w = 2'(i);
        end
        return w;
    endfunction

    // x^5 + x^3 + 1, shift left; never reaches zero from a nonzero seed.
    function automatic logic [4:0] lfsr_next(input logic [4:0] q);
        return {q[3:0], q[1] ^ q[4]};
    endfunction

    // Victim way drawn from two non-adjacent LFSR taps.
    function automatic logic [1:0] lfsr_way(input logic [4:0] q);
        return {q[0], q[2]};
    endfunction

    assign all_vld = &vld_rd_data;
    assign sel_en  = (state_p0 == ST_WAIT) && !fill_cancel;
    assign sel_way = all_vld ? lfsr_way(lfsr_p0) : first_invalid(vld_rd_data);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_l) state_p0 <= ST_IDLE;
        else        state_p0 <= state_nxt;
    end

    // Next-state logic; ack takes priority over cancel in PRESENT.
    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_IDLE:    if (fill_req_vld) state_nxt = ST_WAIT;
            ST_WAIT:    state_nxt = fill_cancel ? ST_IDLE : ST_PRESENT;
            ST_PRESENT: if (fill_way_ack || fill_cancel) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Moore/Mealy outputs decoded from state.
    always_comb begin
        fill_req_rdy = (state_p0 == ST_IDLE);
        vld_rd_en    = (state_p0 == ST_IDLE) && fill_req_vld;
        fill_way_vld = (state_p0 == ST_PRESENT);
    end

    assign vld_rd_idx = fill_req_idx;

    // ---- stage p0: request capture ----
    // Index is latched on accept; it does not need a reset value.
    always_ff @(posedge clk) begin
        if ((state_p0 == ST_IDLE) && fill_req_vld) req_idx_p0 <= fill_req_idx;
    end

    // ---- stage p1: way selection result and LFSR advance ----
    // Selection is registered in WAIT; a cancelled WAIT leaves outputs and LFSR untouched.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            fill_way_p1     <= 2'd0;
            fill_way_idx_p1 <= '0;
            fill_evict_p1   <= 1'b0;
            lfsr_p0         <= LFSR_SD;
        end else if (sel_en) begin
            fill_way_p1     <= sel_way;
            fill_way_idx_p1 <= req_idx_p0;
            fill_evict_p1   <= all_vld;
            if (all_vld) lfsr_p0 <= lfsr_next(lfsr_p0);
        end
    end

    assign fill_way     = fill_way_p1;
    assign fill_way_idx = fill_way_idx_p1;
    assign fill_evict   = fill_evict_p1;

endmodule

// File: tb/tb_lsu_dcache_fill_way_sel.sv
// Self-checking bench for lsu_dcache_fill_way_sel: directed vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_lsu_dcache_fill_way_sel;

    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             fill_req_vld;
    logic [IDX_W-1:0] fill_req_idx;
    logic             fill_req_rdy;
    logic             vld_rd_en;
    logic [IDX_W-1:0] vld_rd_idx;
    logic [3:0]       vld_rd_data;
    logic             fill_cancel;
    logic             fill_way_vld;
    logic [1:0]       fill_way;
    logic [IDX_W-1:0] fill_way_idx;
    logic             fill_evict;
    logic             fill_way_ack;

    int checks = 0;
    int errors = 0;

    // Reference model state: the LFSR value the design should currently hold.
    logic [4:0] m_lfsr;

    always #5 clk = ~clk;

    lsu_dcache_fill_way_sel #(.IDX_W(IDX_W), .LFSR_SD(5'b11111)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .fill_req_vld (fill_req_vld),
        .fill_req_idx (fill_req_idx),
        .fill_req_rdy (fill_req_rdy),
        .vld_rd_en    (vld_rd_en),
        .vld_rd_idx   (vld_rd_idx),
        .vld_rd_data  (vld_rd_data),
        .fill_cancel  (fill_cancel),
        .fill_way_vld (fill_way_vld),
        .fill_way     (fill_way),
        .fill_way_idx (fill_way_idx),
        .fill_evict   (fill_evict),
        .fill_way_ack (fill_way_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected selection from the replacement rules; advances the model LFSR.
    task automatic model_select(input logic [3:0] data, output logic [1:0] way, output logic evict);
        if (data == 4'hF) begin
            way    = {m_lfsr[0], m_lfsr[2]};
            evict  = 1'b1;
            m_lfsr = {m_lfsr[3:0], m_lfsr[1] ^ m_lfsr[4]};
        end else begin
            way   = 2'd0;
            evict = 1'b0;
            for (int i = 3; i >= 0; i--) if (!data[i]) way = 2'(i);
        end
    endtask

    task automatic do_reset();
        rst_l        = 1'b0;
        fill_req_vld = 1'b0;
        fill_req_idx = '0;
        vld_rd_data  = 4'h0;
        fill_cancel  = 1'b0;
        fill_way_ack = 1'b0;
        tick();
        tick();
        rst_l  = 1'b1;
        m_lfsr = 5'b11111;
    endtask

    // One request. mode: 0 ack, 1 cancel in WAIT, 2 cancel+ack in PRESENT, 3 reset in PRESENT.
    task automatic run_req(input logic [IDX_W-1:0] idx, input logic [3:0] data,
                           input int ack_wait, input int mode,
                           output logic [1:0] way_o, output logic evict_o);
        logic [1:0] ew;
        logic       ee;
        way_o   = 2'd0;
        evict_o = 1'b0;
        chk("rdy_idle", 32'(fill_req_rdy), 32'd1);
        fill_req_vld = 1'b1;
        fill_req_idx = idx;
        #1;
        chk("rd_en_c0", 32'(vld_rd_en), 32'd1);
        chk("rd_idx_c0", 32'(vld_rd_idx), 32'(idx));
        tick();
        fill_req_vld = 1'b0;
        fill_req_idx = IDX_W'($urandom);
        vld_rd_data  = data;
        fill_cancel  = (mode == 1);
        fill_way_ack = ($urandom_range(0, 1) == 1);
        #1;
        chk("rdy_wait", 32'(fill_req_rdy), 32'd0);
        chk("vld_wait", 32'(fill_way_vld), 32'd0);
        tick();
        fill_cancel  = 1'b0;
        fill_way_ack = 1'b0;
        vld_rd_data  = 4'($urandom);
        if (mode == 1) begin
            chk("vld_after_cancel", 32'(fill_way_vld), 32'd0);
            chk("rdy_after_cancel", 32'(fill_req_rdy), 32'd1);
            return;
        end
        model_select(data, ew, ee);
        chk("present_vld", 32'(fill_way_vld), 32'd1);
        chk("present_way", 32'(fill_way), 32'(ew));
        chk("present_evict", 32'(fill_evict), 32'(ee));
        chk("present_idx", 32'(fill_way_idx), 32'(idx));
        way_o   = fill_way;
        evict_o = fill_evict;
        if (mode == 3) begin
            rst_l = 1'b0;
            tick();
            rst_l  = 1'b1;
            m_lfsr = 5'b11111;
            chk("rst_pres_vld", 32'(fill_way_vld), 32'd0);
            chk("rst_pres_rdy", 32'(fill_req_rdy), 32'd1);
            chk("rst_pres_way", 32'(fill_way), 32'd0);
            return;
        end
        for (int c = 0; c < ack_wait; c++) begin
            fill_req_vld = 1'b1;
            fill_req_idx = IDX_W'($urandom);
            #1;
            chk("hold_rd_en", 32'(vld_rd_en), 32'd0);
            chk("hold_rdy", 32'(fill_req_rdy), 32'd0);
            tick();
            chk("hold_vld", 32'(fill_way_vld), 32'd1);
            chk("hold_way", 32'({fill_way, fill_evict, fill_way_idx}), 32'({ew, ee, idx}));
        end
        fill_req_vld = 1'b0;
        fill_way_ack = 1'b1;
        fill_cancel  = (mode == 2);
        tick();
        fill_way_ack = 1'b0;
        fill_cancel  = 1'b0;
        chk("vld_after_ack", 32'(fill_way_vld), 32'd0);
        chk("rdy_after_ack", 32'(fill_req_rdy), 32'd1);
    endtask

    typedef struct {
        logic             rst_first;
        logic [IDX_W-1:0] idx;
        logic [3:0]       data;
        logic [1:0]       way;
        logic             evict;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [1:0] w;
        logic       e;

        tbl[0] = '{1'b1, 7'h12, 4'b1011, 2'd2, 1'b0};
        tbl[1] = '{1'b1, 7'h01, 4'b1111, 2'd3, 1'b1};
        tbl[2] = '{1'b0, 7'h02, 4'b1111, 2'd1, 1'b1};
        tbl[3] = '{1'b0, 7'h03, 4'b1111, 2'd1, 1'b1};
        tbl[4] = '{1'b0, 7'h04, 4'b1111, 2'd2, 1'b1};
        tbl[5] = '{1'b1, 7'h55, 4'b0000, 2'd0, 1'b0};
        tbl[6] = '{1'b0, 7'h2A, 4'b1110, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 7'h7F, 4'b1111, 2'd3, 1'b1};
        tbl[8] = '{1'b0, 7'h33, 4'b0111, 2'd3, 1'b0};

        do_reset();
        chk("rst_rdy", 32'(fill_req_rdy), 32'd1);
        chk("rst_rd_en", 32'(vld_rd_en), 32'd0);
        chk("rst_vld", 32'(fill_way_vld), 32'd0);
        chk("rst_outs", 32'({fill_way, fill_evict, fill_way_idx}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_first) do_reset();
            run_req(tbl[i].idx, tbl[i].data, 0, 0, w, e);
            chk($sformatf("tbl%0d_way", i), 32'(w), 32'(tbl[i].way));
            chk($sformatf("tbl%0d_evict", i), 32'(e), 32'(tbl[i].evict));
        end

        // Long hold in PRESENT with blocked requests.
        run_req(7'h44, 4'b1101, 5, 0, w, e);
        chk("hold_seq_way", 32'(w), 32'd1);

        // Cancel in WAIT on an all-valid set must not advance the LFSR.
        do_reset();
        run_req(7'h10, 4'b1111, 0, 1, w, e);
        run_req(7'h11, 4'b1111, 0, 0, w, e);
        chk("cancel_wait_next_way", 32'(w), 32'd3);
        // Cancel together with ack in PRESENT behaves as an ack.
        run_req(7'h12, 4'b1111, 1, 2, w, e);
        chk("cancel_ack_way", 32'(w), 32'd1);

        // Reset in PRESENT reseeds the LFSR.
        run_req(7'h20, 4'b1111, 0, 3, w, e);
        run_req(7'h21, 4'b1111, 0, 0, w, e);
        chk("rst_reseed_way", 32'(w), 32'd3);

        // Randomized traffic against the model; all-valid sets weighted heavily.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] d;
            int         md;
            int         r;
            d  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            r  = $urandom_range(0, 19);
            md = (r < 13) ? 0 : (r < 16) ? 1 : (r < 19) ? 2 : 3;
            run_req(IDX_W'($urandom), d, $urandom_range(0, 3), md, w, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
